// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : multicycle_ctrl_if                                      |
// | Brief    : Shared instruction/data memory request/ready handshake. |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic i_or_d;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output i_or_d,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  i_or_d,
      output mem_ready
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : multicycle_ctrl                                         |
// | Brief    : Moore FSM sequencing a multi-cycle MIPS datapath with   |
// |            handshaked memory and a retired-instruction counter.    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module multicycle_ctrl (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic [5:0]  opcode,
   input  wire logic [5:0]  funct,
   input  wire logic        zero,
   multicycle_ctrl_if.master mem,
   output logic             pc_we,
   output logic             ir_we,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic             ext_op,
   output logic [1:0]       pc_src,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [31:0]      retired
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_R_WB     = 4'd7;
   localparam logic [3:0] S_EXEC_I   = 4'd8;
   localparam logic [3:0] S_I_WB     = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_JR       = 4'd12;
   localparam logic [3:0] S_ILLEGAL  = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;

   logic [3:0]  r_state;
   logic [31:0] r_retired;
   logic [3:0]  w_next;
   logic        w_retire;
   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_i_or_d;

   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
      w_i_or_d   = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_ctrl   = ALU_ADD;
      ext_op     = 1'b0;
      pc_src     = 2'd0;
      illegal    = 1'b0;

      case (r_state)
         S_FETCH: begin
            // PC+4 is written straight from the ALU while IR captures the word
            w_mem_req = 1'b1;
            alu_src_b = 2'd1;
            if (mem.mem_ready) begin
               ir_we  = 1'b1;
               pc_we  = 1'b1;
               w_next = S_DECODE;
            end
         end

         S_DECODE: begin
            alu_src_b = 2'd3;
            ext_op    = 1'b1;
            case (opcode)
               OP_RTYPE: begin
                  case (funct)
                     FN_ADDU, FN_SUBU: w_next = S_EXEC_R;
                     FN_JR:            w_next = S_JR;
                     FN_SLL: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                     end
                     default:          w_next = S_ILLEGAL;
                  endcase
               end
               OP_ORI, OP_LUI: w_next = S_EXEC_I;
               OP_LW, OP_SW:   w_next = S_MEM_ADDR;
               OP_BEQ:         w_next = S_BRANCH;
               OP_J, OP_JAL:   w_next = S_JUMP;
               default:        w_next = S_ILLEGAL;
            endcase
         end

         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            ext_op    = 1'b1;
            w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            w_mem_req = 1'b1;
            w_i_or_d  = 1'b1;
            if (mem.mem_ready) begin
               w_next = S_MEM_WB;
            end
         end

         S_MEM_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = 2'd1;
            w_next     = S_FETCH;
            w_retire   = 1'b1;
         end

         S_MEM_WR: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
            w_i_or_d  = 1'b1;
            if (mem.mem_ready) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end

         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_ctrl  = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            w_next    = S_R_WB;
         end

         S_R_WB: begin
            reg_we   = 1'b1;
            reg_dst  = 2'd1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end

         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_ctrl  = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
            w_next    = S_I_WB;
         end

         S_I_WB: begin
            reg_we   = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end

         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_we     = zero;
            pc_src    = 2'd1;
            w_next    = S_FETCH;
            w_retire  = 1'b1;
         end

         S_JUMP: begin
            // PC already holds PC+4 here, which is the jal link value
            pc_we  = 1'b1;
            pc_src = 2'd2;
            if (opcode == OP_JAL) begin
               reg_we     = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
            end
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end

         S_JR: begin
            pc_we    = 1'b1;
            pc_src   = 2'd3;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end

         S_ILLEGAL: begin
            illegal = 1'b1;
            w_next  = S_ILLEGAL;
         end

         default: w_next = S_FETCH;
      endcase

      // Abandon any in-flight access without a write while reset is held
      if (!reset) begin
         w_mem_req = 1'b0;
         w_mem_we  = 1'b0;
         pc_we     = 1'b0;
         ir_we     = 1'b0;
         reg_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_retired <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
      end
   end

   assign mem.mem_req = w_mem_req;
   assign mem.mem_we  = w_mem_we;
   assign mem.i_or_d  = w_i_or_d;
   assign state       = r_state;
   assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_multicycle_ctrl                                      |
// | Brief    : Directed table-driven bench for multicycle_ctrl.        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_multicycle_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        pc_we, ir_we, reg_we, ext_op, alu_src_a, illegal;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
   logic [2:0]  alu_ctrl;
   logic [3:0]  state;
   logic [31:0] retired;

   multicycle_ctrl_if mi ();

   multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem        (mi.master),
      .pc_we      (pc_we),
      .ir_we      (ir_we),
      .reg_we     (reg_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .ext_op     (ext_op),
      .pc_src     (pc_src),
      .state      (state),
      .illegal    (illegal),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        rdy;
      logic [3:0]  st;
      logic [19:0] w;
      logic [31:0] ret;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   logic [19:0] act;
   assign act = {mi.mem_req, mi.mem_we, mi.i_or_d, pc_we, ir_we, reg_we,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
                 ext_op, pc_src, illegal};

   function automatic logic [19:0] cw(
      input logic req, input logic we, input logic iod, input logic pcwe,
      input logic irwe, input logic regwe, input logic [1:0] dst,
      input logic [1:0] m2r, input logic a, input logic [1:0] b,
      input logic [2:0] alu, input logic ext, input logic [1:0] pcs,
      input logic ill);
      return {req, we, iod, pcwe, irwe, regwe, dst, m2r, a, b, alu, ext, pcs, ill};
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input logic [3:0] st, input logic [19:0] w,
                      input logic [31:0] ret);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.w = w; v.ret = ret;
      tbl.push_back(v);
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      reset     = 1'b0;
      mi.mem_ready = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [19:0] wF1, wF0, wDEC, wMA, wMRD, wMWB, wMWR, wEXA, wEXS, wRWB;
      logic [19:0] wEIO, wEIL, wIWB, wBR0, wBR1, wJ, wJAL, wJR;
      int cyc, rd;
      logic rd_ok, wb_ok;

      wF1  = cw(1,0,0,1,1,0,2'd0,2'd0,0,2'd1,3'd0,0,2'd0,0);
      wF0  = cw(1,0,0,0,0,0,2'd0,2'd0,0,2'd1,3'd0,0,2'd0,0);
      wDEC = cw(0,0,0,0,0,0,2'd0,2'd0,0,2'd3,3'd0,1,2'd0,0);
      wMA  = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,3'd0,1,2'd0,0);
      wMRD = cw(1,0,1,0,0,0,2'd0,2'd0,0,2'd0,3'd0,0,2'd0,0);
      wMWB = cw(0,0,0,0,0,1,2'd0,2'd1,0,2'd0,3'd0,0,2'd0,0);
      wMWR = cw(1,1,1,0,0,0,2'd0,2'd0,0,2'd0,3'd0,0,2'd0,0);
      wEXA = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd0,0,2'd0,0);
      wEXS = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd1,0,2'd0,0);
      wRWB = cw(0,0,0,0,0,1,2'd1,2'd0,0,2'd0,3'd0,0,2'd0,0);
      wEIO = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,3'd2,0,2'd0,0);
      wEIL = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,3'd3,0,2'd0,0);
      wIWB = cw(0,0,0,0,0,1,2'd0,2'd0,0,2'd0,3'd0,0,2'd0,0);
      wBR0 = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd1,0,2'd1,0);
      wBR1 = cw(0,0,0,1,0,0,2'd0,2'd0,1,2'd0,3'd1,0,2'd1,0);
      wJ   = cw(0,0,0,1,0,0,2'd0,2'd0,0,2'd0,3'd0,0,2'd2,0);
      wJAL = cw(0,0,0,1,0,1,2'd2,2'd2,0,2'd0,3'd0,0,2'd2,0);
      wJR  = cw(0,0,0,1,0,0,2'd0,2'd0,0,2'd0,3'd0,0,2'd3,0);

      // addu, subu, ori, lui
      add(6'h00,6'h21,0,1,4'd0,wF1,0);  add(6'h00,6'h21,0,1,4'd1,wDEC,0);
      add(6'h00,6'h21,0,1,4'd6,wEXA,0); add(6'h00,6'h21,0,1,4'd7,wRWB,0);
      add(6'h00,6'h23,0,1,4'd0,wF1,1);  add(6'h00,6'h23,0,1,4'd1,wDEC,1);
      add(6'h00,6'h23,0,1,4'd6,wEXS,1); add(6'h00,6'h23,0,1,4'd7,wRWB,1);
      add(6'h0D,6'h00,0,1,4'd0,wF1,2);  add(6'h0D,6'h00,0,1,4'd1,wDEC,2);
      add(6'h0D,6'h00,0,1,4'd8,wEIO,2); add(6'h0D,6'h00,0,1,4'd9,wIWB,2);
      add(6'h0F,6'h00,0,1,4'd0,wF1,3);  add(6'h0F,6'h00,0,1,4'd1,wDEC,3);
      add(6'h0F,6'h00,0,1,4'd8,wEIL,3); add(6'h0F,6'h00,0,1,4'd9,wIWB,3);
      // sw, nop, j
      add(6'h2B,6'h00,0,1,4'd0,wF1,4);  add(6'h2B,6'h00,0,1,4'd1,wDEC,4);
      add(6'h2B,6'h00,0,1,4'd2,wMA,4);  add(6'h2B,6'h00,0,1,4'd5,wMWR,4);
      add(6'h00,6'h00,0,1,4'd0,wF1,5);  add(6'h00,6'h00,0,1,4'd1,wDEC,5);
      add(6'h02,6'h00,0,1,4'd0,wF1,6);  add(6'h02,6'h00,0,1,4'd1,wDEC,6);
      add(6'h02,6'h00,0,1,4'd11,wJ,6);
      // beq not taken, beq taken
      add(6'h04,6'h00,0,1,4'd0,wF1,7);  add(6'h04,6'h00,0,1,4'd1,wDEC,7);
      add(6'h04,6'h00,0,1,4'd10,wBR0,7);
      add(6'h04,6'h00,1,1,4'd0,wF1,8);  add(6'h04,6'h00,1,1,4'd1,wDEC,8);
      add(6'h04,6'h00,1,1,4'd10,wBR1,8);
      // jal then jr
      add(6'h03,6'h00,0,1,4'd0,wF1,9);  add(6'h03,6'h00,0,1,4'd1,wDEC,9);
      add(6'h03,6'h00,0,1,4'd11,wJAL,9);
      add(6'h00,6'h08,0,1,4'd0,wF1,10); add(6'h00,6'h08,0,1,4'd1,wDEC,10);
      add(6'h00,6'h08,0,1,4'd12,wJR,10);
      // lw with no wait, then a stalled fetch
      add(6'h23,6'h00,0,1,4'd0,wF1,11); add(6'h23,6'h00,0,1,4'd1,wDEC,11);
      add(6'h23,6'h00,0,1,4'd2,wMA,11); add(6'h23,6'h00,0,1,4'd3,wMRD,11);
      add(6'h23,6'h00,0,1,4'd4,wMWB,11);
      add(6'h23,6'h00,0,0,4'd0,wF0,12); add(6'h23,6'h00,0,1,4'd0,wF1,12);

      // Reset forces enables low even in FETCH with mem_ready high
      reset = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mi.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_state", {28'd0, state}, 32'd0);
      chk("reset_retired", retired, 32'd0);
      chk("reset_enables", {27'd0, mi.mem_req, mi.mem_we, pc_we, ir_we, reg_we}, 32'd0);
      reset = 1'b1; mi.mem_ready = 1'b0; #1;
      chk("release_mem_req", {31'd0, mi.mem_req}, 32'd1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z;
         mi.mem_ready = tbl[i].rdy;
         #1;
         chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, tbl[i].st});
         chk($sformatf("vec%0d_ctrl", i), {12'd0, act}, {12'd0, tbl[i].w});
         chk($sformatf("vec%0d_retired", i), retired, tbl[i].ret);
      end

      // lw with three wait cycles in MEM_RD
      apply_reset(2);
      opcode = 6'h23; funct = 6'h00; zero = 1'b0;
      cyc = 0; rd = 0; rd_ok = 1'b1; wb_ok = 1'b0;
      do begin
         mi.mem_ready = !(state == 4'd3 && rd < 3);
         #1;
         if (state == 4'd3) begin
            rd++;
            if (!(mi.mem_req && mi.i_or_d)) rd_ok = 1'b0;
         end
         if (state == 4'd4) wb_ok = (mem_to_reg == 2'd1) && reg_we;
         @(negedge clk);
         cyc++;
      end while (state != 4'd0 && cyc < 20);
      chk("lw_stall_cycles", cyc, 8);
      chk("lw_rd_hold_cycles", rd, 4);
      chk("lw_rd_req_iod", {31'd0, rd_ok}, 32'd1);
      chk("lw_wb_mdr", {31'd0, wb_ok}, 32'd1);
      chk("lw_retired", retired, 32'd1);

      // sw parked in MEM_WR, then reset for two cycles
      opcode = 6'h2B; mi.mem_ready = 1'b1;
      for (int k = 0; k < 10 && state != 4'd5; k++) @(negedge clk);
      mi.mem_ready = 1'b0; #1;
      chk("memwr_state", {28'd0, state}, 32'd5);
      chk("memwr_we_before", {31'd0, mi.mem_we}, 32'd1);
      reset = 1'b0; #1;
      chk("memwr_we_in_reset", {31'd0, mi.mem_we}, 32'd0);
      chk("memwr_req_in_reset", {31'd0, mi.mem_req}, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("memwr_reset_state", {28'd0, state}, 32'd0);
      chk("memwr_reset_retired", retired, 32'd0);
      reset = 1'b1; #1;
      chk("memwr_release_req", {31'd0, mi.mem_req}, 32'd1);

      // Illegal opcode locks up until reset
      opcode = 6'h3F; funct = 6'h00; mi.mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("illegal_state", {28'd0, state}, 32'd13);
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("illegal_hold%0d", k),
             {22'd0, state, illegal, mi.mem_req, mi.mem_we, pc_we, ir_we, reg_we},
             {22'd0, 4'd13, 1'b1, 5'b00000});
         @(negedge clk);
      end
      apply_reset(1);
      #1;
      chk("illegal_reset_state", {28'd0, state}, 32'd0);
      chk("illegal_reset_flag", {31'd0, illegal}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style finite-state controller that sequences a multi-cycle MIPS datapath built from the existing PC, GRF, EXT, ALU and unified memory blocks. The datapath adds IR, MDR, A, B and ALUOut holding registers. Each instruction is broken into fetch / decode / execute / memory / write-back steps. Every memory access is handshaked, so the controller stalls correctly on a slow shared instruction/data memory. It also maintains a retired-instruction counter for the CPI testbench.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset asserted when sampled 0 at a clk edge
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- pc_we  out  1  PC load
- ir_we  out  1  IR load
- reg_we  out  1  GRF write
- reg_dst  out  2  GRF write address: 0 = rt, 1 = rd, 2 = 31
- mem_to_reg  out  2  GRF write data: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B operand: 0 = B, 1 = 4, 2 = ext imm, 3 = ext imm<<2
- alu_ctrl  out  3  ALU operation: 0 = add, 1 = sub, 2 = or, 3 = lui (B<<16)
- ext_op  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend
- pc_src  out  2  PC next value: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28],IR[25:0],00}, 3 = A
- state  out  4  current state, for debug
- illegal  out  1  high while in the ILLEGAL state
- retired  out  32  count of retired instructions

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5
  - EXEC_R = 6, R_WB = 7, EXEC_I = 8, I_WB = 9, BRANCH = 10, JUMP = 11, JR = 12, ILLEGAL = 13
  - Codes 14 and 15 go to FETCH on the next edge; all outputs are 0 in those states.
- Default value of every output not listed for a state is 0.
- FETCH:
  - mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_ctrl = add.
  - When mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 0; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 3, ext_op = 1, add (computes the branch target into ALUOut). Next state by opcode/funct:
  - 000000 with funct 100001 (addu) or 100011 (subu) → EXEC_R
  - 000000 with funct 001000 (jr) → JR
  - 000000 with funct 000000 (nop/sll) → FETCH; retires with no write
  - 001101 (ori) or 001111 (lui) → EXEC_I
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) or 000011 (jal) → JUMP
  - anything else → ILLEGAL
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ext_op = 1, add. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req = 1, i_or_d = 1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 1. Next FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, i_or_d = 1. Wait for mem_ready, then go to FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_ctrl = add for addu, sub for subu. Next R_WB.
- R_WB: reg_we = 1, reg_dst = 1, mem_to_reg = 0. Next FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, ext_op = 0, alu_ctrl = or for ori, lui for lui. Next I_WB.
- I_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 0. Next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, sub; pc_we = zero, pc_src = 1. Next FETCH.
- JUMP: pc_we = 1, pc_src = 2. For jal also reg_we = 1, reg_dst = 2, mem_to_reg = 2; PC already holds PC+4 at this point. Next FETCH.
- JR: pc_we = 1, pc_src = 3. Next FETCH.
- ILLEGAL: illegal = 1, all enables 0. Stays in ILLEGAL until reset.
- Retired counter:
  - retired increments by 1 on the edge that leaves MEM_WB, MEM_WR (on mem_ready), R_WB, I_WB, BRANCH, JUMP or JR, and on DECODE → FETCH for nop.
  - Wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - reset = 0 at an edge: state ← FETCH, retired ← 0.
  - While reset = 0, mem_req, mem_we, pc_we, ir_we and reg_we are combinationally forced to 0, so an access in progress is abandoned with no write.
- The first fetch request appears in the cycle after reset returns to 1.
- Minimum cycles per instruction with mem_ready tied to 1:
  - nop 2; beq, j, jal, jr 3; addu, subu, ori, lui, sw 4; lw 5.
  - Each cycle of mem_ready = 0 during FETCH, MEM_RD or MEM_WR adds one cycle.
- Handshake:
  - mem_req stays high, and the address select and mem_we stay stable, until the cycle in which mem_ready = 1.
  - mem_ready is ignored when mem_req = 0.
- The controller never asserts pc_we and reg_we in the same cycle except in JUMP for jal.

## Test plan
- Reset with reset = 0 for 2 cycles during MEM_WR: mem_we = 0 immediately; state = 0; retired = 0; mem_req = 1 on the first cycle after release.
- addu (opcode 0, funct 0x21) with mem_ready = 1: states 0, 1, 6, 7, 0. reg_we pulses once with reg_dst = 1. retired = 1 after 4 cycles.
- lw (opcode 0x23) with mem_ready low for 3 cycles in MEM_RD: mem_req held with i_or_d = 1 for 4 cycles; total 8 cycles; MEM_WB has mem_to_reg = 1.
- beq with zero = 0, then again with zero = 1: pc_we = 0 in BRANCH, then pc_we = 1 with pc_src = 1; each takes 3 cycles.
- jal (opcode 3): JUMP cycle shows pc_we = 1, reg_we = 1, reg_dst = 2, mem_to_reg = 2, pc_src = 2. Following jr (funct 0x08) shows pc_src = 3.
- Opcode 0x3F: state goes to 13, illegal = 1, no enables asserted for 10 cycles; reset returns state to 0 with illegal = 0.
